// File: rtl/lcd_nn_scaler_if.sv
// Stream interface between the pixel source / write FIFO and lcd_nn_scaler.
//   in_valid/in_ready/in_data/in_sof : source pixel stream (valid/ready handshake)
//   fifo_afull                       : write FIFO almost-full (>=2 free entries when low)
//   out_en/out_data/out_sof          : FIFO write strobe, scaled pixel, first-pixel flag
//   frame_done/err_sof               : one-cycle status pulses
// The scaler uses the slave modport; the source/FIFO side uses master.
interface lcd_nn_scaler_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          fifo_afull;
    logic          out_en;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          frame_done;
    logic          err_sof;

    modport master (
        output in_valid, in_data, in_sof, fifo_afull,
        input  in_ready, out_en, out_data, out_sof, frame_done, err_sof
    );

    modport slave (
        input  in_valid, in_data, in_sof, fifo_afull,
        output in_ready, out_en, out_data, out_sof, frame_done, err_sof
    );
endinterface

// File: rtl/lcd_nn_scaler.sv
// Nearest-neighbour frame scaler. Buffers one IN_W-pixel source line, then
// replays it OUT_W wide as many times as the 16.16 vertical accumulator
// selects that line (0 times on downscale, >=1 on upscale).
// Ports:
//   clk_50m : sole clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : lcd_nn_scaler_if.slave (pixel stream in, FIFO writes out, status)
module lcd_nn_scaler #(
    parameter int DW    = 16,
    parameter int IN_W  = 800,
    parameter int IN_H  = 480,
    parameter int OUT_W = 1024,
    parameter int OUT_H = 600
) (
    input  logic            clk_50m,
    input  logic            rst,
    lcd_nn_scaler_if.slave  bus
);
    localparam int          AW      = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [31:0] STEP_X  = 32'((64'(IN_W) * 64'd65536) / 64'(OUT_W));
    localparam logic [31:0] STEP_Y  = 32'((64'(IN_H) * 64'd65536) / 64'(OUT_H));
    localparam logic [15:0] IN_W_M1 = 16'(IN_W - 1);
    localparam logic [15:0] IN_H_M1 = 16'(IN_H - 1);
    localparam logic [15:0] OUT_W_M1 = 16'(OUT_W - 1);
    localparam logic [15:0] OUT_H_L = 16'(OUT_H);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_EMIT,
        ST_SKIP
    } state_t;

    state_t         state_r, state_s;
    logic [15:0]    col_r, col_s;
    logic [15:0]    src_row_r, src_row_s;
    logic [15:0]    out_row_r, out_row_s;
    logic [15:0]    out_col_r, out_col_s;
    logic [31:0]    acc_x_r, acc_x_s;
    logic [31:0]    acc_y_r, acc_y_s;

    logic           in_ready_r, in_ready_s;
    logic           out_en_r;
    logic [DW-1:0]  out_data_r;
    logic           out_sof_r;
    logic           frame_done_r;
    logic           err_sof_r;

    logic [DW-1:0]  line_buf_r [IN_W];

    logic           xfer_s;
    logic           at_origin_s;
    logic           start_s;
    logic           wr_en_s;
    logic [AW-1:0]  wr_addr_s;
    logic           rd_en_s;
    logic           rd_sof_s;
    logic [AW-1:0]  rd_addr_s;
    logic           done_s;
    logic           err_s;

    assign xfer_s      = bus.in_valid & in_ready_r;
    assign at_origin_s = (col_r == 16'd0) && (src_row_r == 16'd0);
    assign rd_addr_s   = acc_x_r[16 +: AW];

    // Next-state, counter and strobe logic for the load/check/emit/skip sequence.
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        src_row_s = src_row_r;
        out_row_s = out_row_r;
        out_col_s = out_col_r;
        acc_x_s   = acc_x_r;
        acc_y_s   = acc_y_r;
        start_s   = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = col_r[AW-1:0];
        rd_en_s   = 1'b0;
        rd_sof_s  = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Anything before a start-of-frame pixel is dropped.
                if (xfer_s && bus.in_sof) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_LOAD: begin
                if (xfer_s && bus.in_sof && !at_origin_s) begin
                    err_s   = 1'b1;
                    start_s = 1'b1;
                end else if (xfer_s) begin
                    wr_en_s = 1'b1;
                    if (col_r == IN_W_M1) begin
                        state_s = ST_CHECK;
                    end else begin
                        col_s = col_r + 16'd1;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_CHECK: begin
                // Re-emit the buffered line while the vertical accumulator still
                // points at it; otherwise advance to the next source line.
                if ((out_row_r < OUT_H_L) && (acc_y_r[31:16] == src_row_r)) begin
                    state_s   = ST_EMIT;
                    out_col_s = 16'd0;
                    acc_x_s   = 32'd0;
                end else if (src_row_r == IN_H_M1) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    src_row_s = src_row_r + 16'd1;
                    col_s     = 16'd0;
                    if (out_row_r < OUT_H_L) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_SKIP;
                    end
                end
            end
            ST_EMIT: begin
                // fifo_afull low guarantees room for this read plus the one in flight.
                if (!bus.fifo_afull) begin
                    rd_en_s   = 1'b1;
                    rd_sof_s  = (out_row_r == 16'd0) && (out_col_r == 16'd0);
                    acc_x_s   = acc_x_r + STEP_X;
                    out_col_s = out_col_r + 16'd1;
                    if (out_col_r == OUT_W_M1) begin
                        out_row_s = out_row_r + 16'd1;
                        acc_y_s   = acc_y_r + STEP_Y;
                        state_s   = ST_CHECK;
                    end else begin
                        state_s = ST_EMIT;
                    end
                end else begin
                    rd_en_s = 1'b0;
                end
            end
            ST_SKIP: begin
                // All output lines written: drain the rest of the source frame.
                if (xfer_s && bus.in_sof && !at_origin_s) begin
                    err_s   = 1'b1;
                    start_s = 1'b1;
                end else if (xfer_s) begin
                    if (col_r == IN_W_M1) begin
                        col_s = 16'd0;
                        if (src_row_r == IN_H_M1) begin
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            src_row_s = src_row_r + 16'd1;
                        end
                    end else begin
                        col_s = col_r + 16'd1;
                    end
                end else begin
                    col_s = col_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Frame start: the sof pixel lands in buf[0] and loading continues at col 1.
        if (start_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = {AW{1'b0}};
            col_s     = 16'd1;
            src_row_s = 16'd0;
            out_row_s = 16'd0;
            acc_y_s   = 32'd0;
            state_s   = ST_LOAD;
        end else begin
            wr_addr_s = wr_addr_s;
        end

        in_ready_s = (state_s == ST_IDLE) || (state_s == ST_LOAD) || (state_s == ST_SKIP);
    end

    // State, counters, registered outputs and the line-buffer read register.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            col_r        <= 16'd0;
            src_row_r    <= 16'd0;
            out_row_r    <= 16'd0;
            out_col_r    <= 16'd0;
            acc_x_r      <= 32'd0;
            acc_y_r      <= 32'd0;
            in_ready_r   <= 1'b0;
            out_en_r     <= 1'b0;
            out_data_r   <= {DW{1'b0}};
            out_sof_r    <= 1'b0;
            frame_done_r <= 1'b0;
            err_sof_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            col_r        <= col_s;
            src_row_r    <= src_row_s;
            out_row_r    <= out_row_s;
            out_col_r    <= out_col_s;
            acc_x_r      <= acc_x_s;
            acc_y_r      <= acc_y_s;
            in_ready_r   <= in_ready_s;
            out_en_r     <= rd_en_s;
            out_sof_r    <= rd_sof_s;
            frame_done_r <= done_s;
            err_sof_r    <= err_s;
            if (rd_en_s) begin
                out_data_r <= line_buf_r[rd_addr_s];
            end
        end
    end

    // Line-buffer write port.
    always_ff @(posedge clk_50m) begin
        if (wr_en_s) begin
            line_buf_r[wr_addr_s] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_en     = out_en_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_sof    = out_sof_r;
    assign bus.frame_done = frame_done_r;
    assign bus.err_sof    = err_sof_r;
endmodule
